// File: rtl/qdec_pkg.sv
// Shared definitions for the encoder front end.
// Contents: FSM state enum, direction constants, and the Gray-code step
// lookup that classifies a {a,b} transition as CW, CCW, illegal or idle.
package qdec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } fsm_state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef struct packed {
        logic valid;
        logic dir;
        logic illegal;
    } qdec_step_t;

    // prev/cur are {a,b}. CW order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic qdec_step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
        qdec_step_t s;
        s = '0;
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                s.valid = 1'b1;
                s.dir   = DIR_CW;
            end
            4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
                s.valid = 1'b1;
                s.dir   = DIR_CCW;
            end
            4'b0011, 4'b1100, 4'b0110, 4'b1001: s.illegal = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/deb_filter.sv
// Two-flop synchroniser followed by a debounce filter.
// The filtered output follows the synchronised input only after it has
// disagreed with the current filtered value for DEB_CYCLES consecutive cycles.
// Raw edge to filtered edge latency is DEB_CYCLES + 2 cycles.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   raw_i  - asynchronous raw input
//   filt_o - synchronised, debounced output
module deb_filter #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);
    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            // The DEB_CYCLES-th disagreeing cycle commits the new value.
            if (cnt_q == CntLast) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/enc_frontend.sv
// Rotary encoder and mode button front end for the cog block.
// Debounces A/B/btn, decodes Gray-code steps, and turns each step into a
// cnt pulse PULSE_LEN cycles wide followed by a one-cycle gap. Steps that
// arrive while busy are queued (same direction accumulates up to PEND_MAX,
// opposite direction cancels). A filtered btn rising edge toggles mode and
// flushes the queue; a pulse already in flight still completes.
// Optional feature macro: QDEC_ERR_EN adds err_cnt, a saturating count of
// illegal (both-bit) transitions.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   enc_a, enc_b   - raw quadrature inputs
//   btn            - raw mode push-button, active high
//   cnt            - step strobe, high PULSE_LEN cycles per step
//   dir            - step direction (1 = CW), stable over the pulse
//   mode           - mode toggle state
//   err_cnt        - illegal-transition count (QDEC_ERR_EN only)
module enc_frontend
    import qdec_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned PULSE_LEN  = 4,
    parameter int unsigned PEND_MAX   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       btn,
    output logic       cnt,
    output logic       dir,
    output logic       mode
`ifdef QDEC_ERR_EN
    ,
    output logic [7:0] err_cnt
`endif
);
    localparam int unsigned TmrW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int unsigned PendW = $clog2(PEND_MAX + 1);
    localparam logic [TmrW-1:0]  TmrLoad = TmrW'(PULSE_LEN - 1);
    localparam logic [PendW-1:0] PendSat = PendW'(PEND_MAX);

    logic filt_a, filt_b, filt_btn;

    deb_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (enc_a),
        .filt_o (filt_a)
    );

    deb_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (enc_b),
        .filt_o (filt_b)
    );

    deb_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (btn),
        .filt_o (filt_btn)
    );

    fsm_state_e       state_q, state_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             pend_dir_q, pend_dir_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic [1:0]       ab_prev_q;
    logic             btn_prev_q;

    qdec_step_t step;
    logic       toggle;

    assign step   = gray_step(ab_prev_q, {filt_a, filt_b});
    assign toggle = filt_btn & ~btn_prev_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        dir_d      = dir_q;
        mode_d     = mode_q;

        if (toggle) begin
            mode_d = ~mode_q;
        end

        // Queue update happens before the GAP decision so a step landing in
        // GAP is seen by that same cycle's evaluation.
        if (state_q != IDLE && step.valid) begin
            if (pend_d == '0) begin
                pend_dir_d = step.dir;
                pend_d     = 1'b1;
            end else if (step.dir == pend_dir_d) begin
                if (pend_d != PendSat) begin
                    pend_d = pend_d + 1'b1;
                end
            end else begin
                pend_d = pend_d - 1'b1;
            end
        end
        if (toggle) begin
            pend_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (step.valid) begin
                    dir_d   = step.dir;
                    timer_d = TmrLoad;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (pend_d != '0) begin
                    pend_d  = pend_d - 1'b1;
                    dir_d   = pend_dir_d;
                    timer_d = TmrLoad;
                    state_d = PULSE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pend_q     <= '0;
            pend_dir_q <= 1'b0;
            dir_q      <= 1'b0;
            mode_q     <= 1'b0;
            ab_prev_q  <= 2'b00;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            ab_prev_q  <= {filt_a, filt_b};
            btn_prev_q <= filt_btn;
        end
    end

    // Decoded straight from the state flop, so reset removes it immediately.
    assign cnt  = (state_q == PULSE);
    assign dir  = dir_q;
    assign mode = mode_q;

`ifdef QDEC_ERR_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (step.illegal && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_illegal;
    assign unused_illegal = step.illegal;
`endif

endmodule

// File: tb/tb_enc_frontend.sv
// Self-checking bench for enc_frontend (DEB_CYCLES=4, PULSE_LEN=4, PEND_MAX=3).
// A cycle-level reference model (delay line, run-length debounce, Gray
// position arithmetic, slot-count pulse timeline) is compared every cycle,
// plus directed pulse-count checks. Build with QDEC_ERR_EN to cover err_cnt.
module tb_enc_frontend;
    localparam int DEB  = 4;
    localparam int PLEN = 4;
    localparam int PMAX = 3;

    logic clk = 1'b0;
    logic rst_n, enc_a, enc_b, btn;
    logic cnt, dir, mode;
`ifdef QDEC_ERR_EN
    logic [7:0] err_cnt;
`endif

    enc_frontend #(
        .DEB_CYCLES (DEB),
        .PULSE_LEN  (PLEN),
        .PEND_MAX   (PMAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .btn     (btn),
        .cnt     (cnt),
        .dir     (dir),
        .mode    (mode)
`ifdef QDEC_ERR_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state.
    int m_sync [3][2];
    int m_filt [3];
    int m_run  [3];
    int m_prev_ab, m_prev_btn;
    int m_slot;     // 0 idle, 1..PLEN pulse cycle number, PLEN+1 gap
    int m_dir, m_mode, m_pend, m_pdir, m_err, m_pulses;

    int  d_pulses = 0;
    int  d_hi     = 0;
    bit  d_cnt_prev = 1'b0;
    int  cyc = 0;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sync[i][0] = 0;
            m_sync[i][1] = 0;
            m_filt[i]    = 0;
            m_run[i]     = 0;
        end
        m_prev_ab = 0; m_prev_btn = 0;
        m_slot = 0; m_dir = 0; m_mode = 0; m_pend = 0; m_pdir = 0; m_err = 0;
    endfunction

    // Position of {a,b} around the CW cycle 00,01,11,10.
    function automatic int gray_pos(input int ab);
        case (ab)
            0: return 0;
            1: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void model_edge(input int a, input int b, input int bt);
        int cur_ab, cur_btn, delta, sdir, seen;
        bit stp, rise;
        int raw [3];
        cur_ab  = m_filt[0] * 2 + m_filt[1];
        cur_btn = m_filt[2];
        delta   = (gray_pos(cur_ab) - gray_pos(m_prev_ab) + 4) % 4;
        stp     = (delta == 1) || (delta == 3);
        sdir    = (delta == 1) ? 1 : 0;
        rise    = (cur_btn == 1) && (m_prev_btn == 0);
        if (delta == 2 && m_err < 255) m_err++;
        if (rise) m_mode = 1 - m_mode;
        if (m_slot == 0) begin
            if (stp) begin
                m_slot = 1; m_dir = sdir; m_pulses++;
            end
        end else begin
            if (stp) begin
                if (m_pend == 0) begin
                    m_pend = 1; m_pdir = sdir;
                end else if (sdir == m_pdir) begin
                    if (m_pend < PMAX) m_pend++;
                end else begin
                    m_pend--;
                end
            end
            if (rise) m_pend = 0;
            if (m_slot == PLEN + 1) begin
                if (m_pend > 0) begin
                    m_pend--; m_dir = m_pdir; m_slot = 1; m_pulses++;
                end else begin
                    m_slot = 0;
                end
            end else begin
                m_slot++;
            end
        end
        m_prev_ab  = cur_ab;
        m_prev_btn = cur_btn;
        raw[0] = a; raw[1] = b; raw[2] = bt;
        for (int i = 0; i < 3; i++) begin
            seen = m_sync[i][1];
            if (seen != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_filt[i] = seen;
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_sync[i][1] = m_sync[i][0];
            m_sync[i][0] = raw[i];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(int'(enc_a), int'(enc_b), int'(btn));
        else model_reset();
        #1;
        cyc++;
        check_eq($sformatf("cnt@%0d", cyc), int'(cnt), (m_slot >= 1 && m_slot <= PLEN) ? 1 : 0);
        check_eq($sformatf("dir@%0d", cyc), int'(dir), m_dir);
        check_eq($sformatf("mode@%0d", cyc), int'(mode), m_mode);
`ifdef QDEC_ERR_EN
        check_eq($sformatf("err_cnt@%0d", cyc), int'(err_cnt), m_err);
`endif
        if (cnt && !d_cnt_prev) d_pulses++;
        if (cnt) d_hi++;
        d_cnt_prev = cnt;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, h0;
        bit seen;
        rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; btn = 1'b0;
        model_reset();
        m_pulses = 0;
        run(3);
        check_eq("reset_cnt", int'(cnt), 0);
        check_eq("reset_dir", int'(dir), 0);
        check_eq("reset_mode", int'(mode), 0);
        rst_n = 1'b1;
        run(20);

        // One full CW revolution, 20 cycles per phase.
        p0 = d_pulses; h0 = d_hi;
        enc_b = 1'b1; run(20);
        enc_a = 1'b1; run(20);
        enc_b = 1'b0; run(20);
        enc_a = 1'b0; run(30);
        check_eq("cw_pulses", d_pulses - p0, 4);
        check_eq("cw_hi_cycles", d_hi - h0, 16);

        // Bounce on A, settling high: a single step.
        p0 = d_pulses;
        for (int i = 0; i < 15; i++) begin
            enc_a = ~enc_a; run(2);
        end
        run(40);
        check_eq("bounce_pulses", d_pulses - p0, 1);
        enc_a = 1'b0; run(40);

        // Burst of 8 CW steps, each channel held 5 cycles: queue saturates.
        p0 = d_pulses; h0 = d_hi;
        for (int k = 0; k < 2; k++) begin
            enc_b = 1'b1; run(1);
            enc_a = 1'b1; run(4);
            enc_b = 1'b0; run(1);
            enc_a = 1'b0; run(4);
        end
        run(60);
        check_eq("burst_pulses", d_pulses - p0, 7);
        check_eq("burst_hi_cycles", d_hi - h0, 28);

        // CW step queued, then a CCW step landing in the gap cancels it.
        p0 = d_pulses;
        enc_b = 1'b1; run(1);
        enc_a = 1'b1; run(4);
        enc_a = 1'b0; run(30);
        check_eq("cancel_pulses", d_pulses - p0, 1);
        enc_b = 1'b0; run(30);

        // Mode toggle with two steps queued: pulse completes, queue flushed.
        p0 = d_pulses;
        enc_b = 1'b1; run(1);
        enc_a = 1'b1; run(3);
        enc_b = 1'b0; run(1);
        btn = 1'b1; run(10);
        btn = 1'b0; run(30);
        check_eq("mode_pulses", d_pulses - p0, 1);
        check_eq("mode_value", int'(mode), 1);
        enc_a = 1'b0; run(30);

        // Illegal both-bit jumps: no steps; err_cnt saturates.
        p0 = d_pulses;
        enc_a = 1'b1; enc_b = 1'b1; run(8);
`ifdef QDEC_ERR_EN
        check_eq("err_first", int'(err_cnt), 1);
`endif
        for (int i = 1; i < 300; i++) begin
            enc_a = ~enc_a; enc_b = ~enc_b; run(8);
        end
        check_eq("illegal_pulses", d_pulses - p0, 0);
`ifdef QDEC_ERR_EN
        check_eq("err_sat", int'(err_cnt), 255);
`endif
        enc_a = 1'b0; enc_b = 1'b0; run(20);

        // Random stimulus including bounce, illegal jumps and presses.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) enc_a = ~enc_a;
            else if (r <= 6) enc_b = ~enc_b;
            else if (r == 7) begin enc_a = ~enc_a; enc_b = ~enc_b; end
            else if (r == 8) btn = ~btn;
            run($urandom_range(1, 10));
        end
        enc_a = 1'b0; enc_b = 1'b0; btn = 1'b0;
        run(60);
        check_eq("model_pulse_total", d_pulses, m_pulses);

        // Asynchronous reset in the middle of a pulse.
        enc_b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (cnt) seen = 1'b1;
        end
        check_eq("rst_pulse_started", int'(seen), 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cnt", int'(cnt), 0);
        check_eq("rst_mid_dir", int'(dir), 0);
        check_eq("rst_mid_mode", int'(mode), 0);
`ifdef QDEC_ERR_EN
        check_eq("rst_mid_err", int'(err_cnt), 0);
`endif
        model_reset();
        d_cnt_prev = 1'b0;
        enc_b = 1'b0;
        run(3);
        rst_n = 1'b1;
        p0 = d_pulses;
        run(30);
        check_eq("post_rst_pulses", d_pulses - p0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
